uart_rx: RTL and testbench

Serial receiver that sits directly downstream of the team's 16x-oversampled UART transmitter and consumes its serial line. It recovers 8N1 frames (LSB first) from an asynchronous input using the same shared oversampling tick, with mid-bit sampling. It presents each received byte with a one-cycle valid pulse, or a framing-error pulse when the stop bit is bad.

---
 rtl/uart_rx.sv | 132 +++++++++++++
 tb/tb_uart_rx.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 serial receiver driven by the shared oversampling tick. Each bit is
// sampled at its midpoint. Each frame ends in one rx_valid or framing_error pulse.
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 rx_serial,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 framing_error,
  output logic                 rx_busy
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     tick_count_q, tick_count_d;
  logic [IDX_W-1:0]     bit_index_q, bit_index_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 sync1_q, rx_sync_q, rx_prev_q;

  // Synchronizer and edge-detect flops idle high, like the line itself.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q   <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      sync1_q   <= rx_serial;
      rx_sync_q <= sync1_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      tick_count_q <= '0;
      bit_index_q  <= '0;
      shift_q      <= '0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_count_q <= tick_count_d;
      bit_index_q  <= bit_index_d;
      shift_q      <= shift_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    tick_count_d = tick_count_q;
    bit_index_d  = bit_index_q;
    shift_d      = shift_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    frame_err_d  = 1'b0;

    case (state_q)
      IDLE: begin
        // Only a real high-to-low transition starts a frame; a held-low line never does.
        if (rx_prev_q && !rx_sync_q) begin
          state_d      = START;
          tick_count_d = '0;
        end
      end
      START: begin
        if (tick) begin
          if (tick_count_q == CNT_W'(OVERSAMPLE/2 - 1)) begin
            tick_count_d = '0;
            bit_index_d  = '0;
            state_d      = rx_sync_q ? IDLE : DATA;
          end else begin
            tick_count_d = tick_count_q + CNT_W'(1);
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (tick_count_q == CNT_W'(OVERSAMPLE - 1)) begin
            tick_count_d = '0;
            shift_d      = {rx_sync_q, shift_q[DATA_BITS-1:1]};
            if (bit_index_q == IDX_W'(DATA_BITS - 1)) begin
              state_d = STOP;
            end else begin
              bit_index_d = bit_index_q + IDX_W'(1);
            end
          end else begin
            tick_count_d = tick_count_q + CNT_W'(1);
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (tick_count_q == CNT_W'(OVERSAMPLE - 1)) begin
            tick_count_d = '0;
            state_d      = IDLE;
            if (rx_sync_q) begin
              rx_data_d  = shift_q;
              rx_valid_d = 1'b1;
            end else begin
              frame_err_d = 1'b1;
            end
          end else begin
            tick_count_d = tick_count_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign framing_error = frame_err_q;
  assign rx_busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: a tick-timed line driver plays the transmitter, and a
// scoreboard monitor checks every rx_valid / framing_error pulse.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       rx_serial = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       framing_error;
  logic       rx_busy;

  bit tick_en = 1'b1;
  int div = 0;
  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic       fe;
    logic [7:0] data;
  } exp_t;
  exp_t sb[$];

  uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
    .clk(clk),
    .reset(reset),
    .tick(tick),
    .rx_serial(rx_serial),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .framing_error(framing_error),
    .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;

  // One tick every 4 clk, updated on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      div  = (div + 1) % 4;
      tick = tick_en && (div == 0);
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every output pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rx_valid && framing_error) begin
      vectors++;
      miscompares++;
      $display("FAIL both_pulses: rx_valid=1 framing_error=1, expected at most one");
    end else if (rx_valid || framing_error) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_pulse: valid=%0b fe=%0b data=%0h, expected no pulse",
                 rx_valid, framing_error, rx_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (framing_error !== e.fe || rx_data !== e.data) begin
          miscompares++;
          $display("FAIL pulse: fe=%0b data=%0h, expected fe=%0b data=%0h",
                   framing_error, rx_data, e.fe, e.data);
        end
      end
    end
  end

  task automatic wait_tick();
    do @(posedge clk); while (tick !== 1'b1);
    @(negedge clk);
  endtask

  // Drives start, data (LSB first) and stop, 16 ticks per bit, for n_ticks ticks.
  task automatic send_frame(input logic [7:0] d, input logic stop_b,
                            input int n_ticks, input int freeze_at);
    logic [9:0] fr;
    fr = {stop_b, d, 1'b0};
    for (int t = 0; t < n_ticks; t++) begin
      rx_serial = fr[t/16];
      wait_tick();
      if (t == 4) check("busy_start", {31'd0, rx_busy}, 32'd1);
      if (t == freeze_at) begin
        check("tc_pre_freeze", {28'd0, dut.tick_count_q}, (freeze_at + 1 - 8) % 16);
        @(posedge clk);
        tick_en = 1'b0;
        repeat (100) @(posedge clk);
        @(negedge clk);
        check("tc_post_freeze", {28'd0, dut.tick_count_q}, (freeze_at + 1 - 8) % 16);
        check("busy_freeze", {31'd0, rx_busy}, 32'd1);
        @(posedge clk);
        tick_en = 1'b1;
      end
      if (n_ticks == 160 && t == 150) check("busy_pre_stop", {31'd0, rx_busy}, 32'd1);
      if (n_ticks == 160 && t == 151) begin
        check("busy_after_stop", {31'd0, rx_busy}, 32'd0);
        check("pulse_latency", {31'd0, rx_valid | framing_error}, 32'd1);
      end
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_data", {24'd0, rx_data}, 32'h00);
    check("rst_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_fe", {31'd0, framing_error}, 32'd0);
    check("rst_busy", {31'd0, rx_busy}, 32'd0);
    reset = 1'b0;
    repeat (5) @(posedge clk);

    // Single frame 0xA5
    sb.push_back('{1'b0, 8'hA5});
    wait_tick();
    send_frame(8'hA5, 1'b1, 160, -1);
    repeat (16) wait_tick();
    check("sb_a5", sb.size(), 32'd0);

    // Back-to-back 0x00 then 0xFF
    sb.push_back('{1'b0, 8'h00});
    sb.push_back('{1'b0, 8'hFF});
    wait_tick();
    send_frame(8'h00, 1'b1, 160, -1);
    send_frame(8'hFF, 1'b1, 160, -1);
    repeat (16) wait_tick();
    check("sb_b2b", sb.size(), 32'd0);
    check("data_b2b", {24'd0, rx_data}, 32'hFF);

    // Glitch: low for 3 ticks, rejected at the start-bit midpoint
    wait_tick();
    rx_serial = 1'b0;
    repeat (3) wait_tick();
    check("glitch_busy", {31'd0, rx_busy}, 32'd1);
    rx_serial = 1'b1;
    repeat (4) wait_tick();
    check("glitch_busy_pre_mid", {31'd0, rx_busy}, 32'd1);
    wait_tick();
    check("glitch_idle", {31'd0, rx_busy}, 32'd0);
    repeat (16) wait_tick();
    check("glitch_data", {24'd0, rx_data}, 32'hFF);

    // Framing error: 0x11 good, then 0x3C with a low stop bit and held-low line
    sb.push_back('{1'b0, 8'h11});
    wait_tick();
    send_frame(8'h11, 1'b1, 160, -1);
    sb.push_back('{1'b1, 8'h11});
    send_frame(8'h3C, 1'b0, 160, -1);
    repeat (48) wait_tick();
    check("fe_no_restart", {31'd0, rx_busy}, 32'd0);
    check("fe_data_kept", {24'd0, rx_data}, 32'h11);
    rx_serial = 1'b1;
    repeat (16) wait_tick();
    sb.push_back('{1'b0, 8'h3C});
    send_frame(8'h3C, 1'b1, 160, -1);
    repeat (16) wait_tick();
    check("sb_fe", sb.size(), 32'd0);

    // Reset during data bit 4 of 0x5A, then a clean 0x5A
    wait_tick();
    send_frame(8'h5A, 1'b1, 88, -1);
    @(posedge clk);
    reset = 1'b1;
    rx_serial = 1'b1;
    @(negedge clk);
    check("midrst_data", {24'd0, rx_data}, 32'h00);
    check("midrst_valid", {31'd0, rx_valid}, 32'd0);
    check("midrst_fe", {31'd0, framing_error}, 32'd0);
    check("midrst_busy", {31'd0, rx_busy}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (32) wait_tick();
    check("midrst_quiet", sb.size(), 32'd0);
    sb.push_back('{1'b0, 8'h5A});
    send_frame(8'h5A, 1'b1, 160, -1);
    repeat (16) wait_tick();
    check("data_5a", {24'd0, rx_data}, 32'h5A);

    // Tick frozen for 100 clk in the middle of data bit 3 of 0xC3
    sb.push_back('{1'b0, 8'hC3});
    wait_tick();
    send_frame(8'hC3, 1'b1, 160, 68);
    repeat (16) wait_tick();
    check("data_c3", {24'd0, rx_data}, 32'hC3);
    check("sb_final", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
